daq_sample_writer: RTL

Per-channel capture engine on the DAQ side: accepts ADC samples already in the `wb_clk` domain and buffers them in a small FIFO. Writes them as a Wishbone master into the shared SRAM ring starting at a programmed address. Pulses `frame_done` when a full frame is stored; this is the signal that drives the DSP `begin_equation` input. It sits directly upstream of the DSP and RAM, one instance per ADC channel inside `wb_daq_top`.

---
 rtl/daq_sample_writer_pkg.sv | 26 ++
 rtl/daq_sample_fifo.sv | 61 ++++++
 rtl/daq_sample_writer.sv | 228 ++++++++++++++++++++++
 3 files changed

// File: rtl/daq_sample_writer_pkg.sv
// daq_sample_writer_pkg: writer FSM encoding, Wishbone CTI codes
// and frame-length helper shared by the sample writer files.
package daq_sample_writer_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_REQ,
    ST_WAIT,
    ST_ERROR
  } state_t;

  localparam logic [2:0] CTI_CLASSIC = 3'b000;
  localparam logic [2:0] CTI_INCR    = 3'b010;
  localparam logic [2:0] CTI_EOB     = 3'b111;

  localparam logic [3:0] SEL_WORD = 4'hF;
  localparam logic [1:0] BTE_LIN  = 2'b00;

  // A zero-length frame behaves as a single-sample frame.
  function automatic logic [15:0] eff_len(
    input logic [15:0] len
  );
    return (len == 16'd0) ? 16'd1 : len;
  endfunction

endpackage

// File: rtl/daq_sample_fifo.sv
// daq_sample_fifo: first-word-fall-through sample buffer.
// Exposes the head and the entry behind it for back-to-back issue.
module daq_sample_fifo
  import daq_sample_writer_pkg::*;
#(
  parameter int DEPTH = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   push,
  input  logic                   pop,
  input  logic [31:0]            data,
  output logic [31:0]            head,
  output logic [31:0]            head_nxt,
  output logic [$clog2(DEPTH):0] count,
  output logic                   full,
  output logic                   empty
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW-1:0] P_ONE = 1;
  localparam logic [AW:0]   C_ONE = 1;
  localparam logic [AW:0]   C_MAX = DEPTH;

  logic [31:0]   mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  assign empty    = (count == '0);
  assign full     = (count == C_MAX);
  assign do_pop   = pop && !empty;
  assign do_push  = push && (!full || do_pop);
  assign head     = mem[rd_ptr];
  assign head_nxt = mem[rd_ptr + P_ONE];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push)
        wr_ptr <= wr_ptr + P_ONE;
      if (do_pop)
        rd_ptr <= rd_ptr + P_ONE;
      case ({do_push, do_pop})
        2'b10:   count <= count + C_ONE;
        2'b01:   count <= count - C_ONE;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push)
      mem[wr_ptr] <= data;
  end

endmodule

// File: rtl/daq_sample_writer.sv
// daq_sample_writer: drains ADC samples into an SRAM frame ring via Wishbone.
// Define DAQ_SAMPLE_WRITER_BURST_EN for incrementing bursts (classic otherwise).
module daq_sample_writer
  import daq_sample_writer_pkg::*;
#(
  parameter int FIFO_DEPTH = 16,
  parameter int ADR_WIDTH  = 32
) (
  input  logic                 wb_clk,
  input  logic                 wb_rst,
  input  logic                 enable,
  input  logic [ADR_WIDTH-1:0] start_address,
  input  logic [15:0]          frame_length,
  input  logic                 sample_valid,
  input  logic [31:0]          sample_data,
  output logic [ADR_WIDTH-1:0] wb_master_adr_o,
  output logic [31:0]          wb_master_dat_o,
  output logic [3:0]           wb_master_sel_o,
  output logic                 wb_master_we_o,
  output logic                 wb_master_cyc_o,
  output logic                 wb_master_stb_o,
  output logic [2:0]           wb_master_cti_o,
  output logic [1:0]           wb_master_bte_o,
  input  logic [31:0]          wb_master_dat_i,
  input  logic                 wb_master_ack_i,
  input  logic                 wb_master_err_i,
  input  logic                 wb_master_rty_i,
  output logic                 frame_done,
  output logic                 overflow,
  output logic                 bus_error,
  output logic                 busy
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam logic [CW-1:0]        C_ONE = 1;
  localparam logic [ADR_WIDTH-1:0] WSTEP = 4;

  state_t state;
  state_t state_d;

  logic [ADR_WIDTH-1:0] ptr;
  logic [ADR_WIDTH-1:0] ptr_cur;
  logic [ADR_WIDTH-1:0] adr_d;
  logic [15:0]          idx;
  logic [15:0]          flen;
  logic [31:0]          head;
  logic [31:0]          head_nxt;
  logic [31:0]          dat_d;
  logic [CW-1:0]        count;
  logic [2:0]           cti_d;
  logic [2:0]           cti_issue;
  logic                 en_q;
  logic                 en_rise;
  logic                 push;
  logic                 pop;
  logic                 drop;
  logic                 full;
  logic                 empty;
  logic                 last;
  logic                 more;
  logic                 cyc_d;
  logic                 stb_d;

  wire unused_dat_i = ^wb_master_dat_i;

  assign en_rise = enable && !en_q;
  assign ptr_cur = en_rise ? start_address : ptr;
  assign flen    = eff_len(frame_length);
  assign last    = ({1'b0, idx} + 17'd1) >= {1'b0, flen};
  assign pop     = (state == ST_WAIT)
                && wb_master_ack_i && !wb_master_err_i;
  assign push    = sample_valid && enable && (!full || pop);
  assign drop    = sample_valid && enable && full && !pop;
  assign more    = enable && ((count > C_ONE) || push);
  assign busy    = wb_master_cyc_o || !empty;

  assign wb_master_bte_o = BTE_LIN;

`ifdef DAQ_SAMPLE_WRITER_BURST_EN
  logic [15:0]   idx_cur;
  logic [CW-1:0] cnt_after;
  logic [2:0]    cti_cont;
  logic          last_cur;
  logic          last_nxt;

  assign idx_cur   = en_rise ? 16'd0 : idx;
  assign last_cur  = ({1'b0, idx_cur} + 17'd1) >= {1'b0, flen};
  assign last_nxt  = ({1'b0, idx} + 17'd2) >= {1'b0, flen};
  assign cnt_after = count - C_ONE + {{(CW-1){1'b0}}, push};
  assign cti_issue = ((count == C_ONE) || last_cur)
                   ? CTI_EOB : CTI_INCR;
  assign cti_cont  = ((cnt_after == C_ONE) || last_nxt)
                   ? CTI_EOB : CTI_INCR;
`else
  wire unused_nxt = ^head_nxt;
  assign cti_issue = CTI_CLASSIC;
`endif

  daq_sample_fifo #(
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk     (wb_clk),
    .rst_n   (wb_rst),
    .push    (push),
    .pop     (pop),
    .data    (sample_data),
    .head    (head),
    .head_nxt(head_nxt),
    .count   (count),
    .full    (full),
    .empty   (empty)
  );

  always_comb begin
    state_d = state;
    cyc_d   = 1'b0;
    stb_d   = 1'b0;
    adr_d   = wb_master_adr_o;
    dat_d   = wb_master_dat_o;
    cti_d   = wb_master_cti_o;
    unique case (state)
      ST_IDLE: begin
        if (enable && !empty) begin
          state_d = ST_REQ;
          cyc_d   = 1'b1;
          stb_d   = 1'b1;
          adr_d   = ptr_cur;
          dat_d   = head;
          cti_d   = cti_issue;
        end
      end
      ST_REQ: begin
        state_d = ST_WAIT;
        cyc_d   = 1'b1;
        stb_d   = 1'b1;
        adr_d   = ptr;
        dat_d   = head;
        cti_d   = cti_issue;
      end
      ST_WAIT: begin
        cyc_d = 1'b1;
        stb_d = 1'b1;
        if (wb_master_err_i) begin
          state_d = ST_ERROR;
          cyc_d   = 1'b0;
          stb_d   = 1'b0;
        end else if (wb_master_ack_i) begin
          if (!more) begin
            state_d = ST_IDLE;
            cyc_d   = 1'b0;
            stb_d   = 1'b0;
          end
`ifdef DAQ_SAMPLE_WRITER_BURST_EN
          else if (wb_master_cti_o == CTI_EOB) begin
            state_d = ST_IDLE;
            cyc_d   = 1'b0;
            stb_d   = 1'b0;
          end else begin
            // Burst continues: next word is already behind the head.
            adr_d = ptr + WSTEP;
            dat_d = head_nxt;
            cti_d = cti_cont;
          end
`else
          else begin
            state_d = ST_REQ;
            stb_d   = 1'b0;
          end
`endif
        end else if (wb_master_rty_i) begin
          state_d = ST_REQ;
          stb_d   = 1'b0;
        end
      end
      ST_ERROR: begin
        if (!enable)
          state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge wb_clk) begin
    if (!wb_rst) begin
      state           <= ST_IDLE;
      wb_master_adr_o <= '0;
      wb_master_dat_o <= '0;
      wb_master_sel_o <= '0;
      wb_master_we_o  <= 1'b0;
      wb_master_cyc_o <= 1'b0;
      wb_master_stb_o <= 1'b0;
      wb_master_cti_o <= CTI_CLASSIC;
      en_q            <= 1'b0;
      ptr             <= '0;
      idx             <= '0;
      frame_done      <= 1'b0;
      overflow        <= 1'b0;
      bus_error       <= 1'b0;
    end else begin
      state           <= state_d;
      wb_master_adr_o <= adr_d;
      wb_master_dat_o <= dat_d;
      wb_master_sel_o <= cyc_d ? SEL_WORD : 4'h0;
      wb_master_we_o  <= cyc_d;
      wb_master_cyc_o <= cyc_d;
      wb_master_stb_o <= stb_d;
      wb_master_cti_o <= cti_d;
      en_q            <= enable;
      frame_done      <= pop && last;
      overflow        <= overflow | drop;
      bus_error       <= bus_error
                       | ((state == ST_WAIT) && wb_master_err_i);
      if (pop) begin
        if (last) begin
          ptr <= start_address;
          idx <= '0;
        end else begin
          ptr <= ptr + WSTEP;
          idx <= idx + 16'd1;
        end
      end else if (en_rise) begin
        ptr <= start_address;
        idx <= '0;
      end
    end
  end

endmodule
